// File: rtl/output_vc_status_tracker_if.sv
// Handshake bundle between the allocator/crossbar/credit side and one
// output-port VC status tracker.
interface output_vc_status_tracker_if #(
  parameter int V  = 4,
  parameter int CW = 3
);
  logic [V-1:0]    ovc_allocated;
  logic            flit_sent;
  logic [V-1:0]    flit_sent_vc;
  logic            flit_sent_is_tail;
  logic [V-1:0]    credit_in;
  logic [V-1:0]    ovc_avb;
  logic            any_ovc_avb;
  logic [V-1:0]    ovc_not_full;
  logic [V-1:0]    ovc_nearly_full;
  logic [V*CW-1:0] credit_count;
  logic            err_credit_overflow;
  logic            err_credit_underflow;
  logic            err_bad_alloc;
  logic            err_bad_send;

  modport master (
    output ovc_allocated, flit_sent, flit_sent_vc, flit_sent_is_tail, credit_in,
    input  ovc_avb, any_ovc_avb, ovc_not_full, ovc_nearly_full, credit_count,
           err_credit_overflow, err_credit_underflow, err_bad_alloc, err_bad_send
  );

  modport slave (
    input  ovc_allocated, flit_sent, flit_sent_vc, flit_sent_is_tail, credit_in,
    output ovc_avb, any_ovc_avb, ovc_not_full, ovc_nearly_full, credit_count,
           err_credit_overflow, err_credit_underflow, err_bad_alloc, err_bad_send
  );
endinterface

// File: rtl/output_vc_status_tracker.sv
// Per-output-port tracker of downstream OVC ownership and credit counts,
// feeding availability / not-full masks to the VC/switch allocator.
module output_vc_status_tracker #(
  parameter int    V               = 4,
  parameter int    B               = 4,
  parameter string VC_REALLOC_TYPE = "NONATOMIC",
  parameter bit    DEBUG_EN        = 1'b1
) (
  input logic                        clk,
  input logic                        reset,
  output_vc_status_tracker_if.slave  bus
);
  localparam int            CW     = $clog2(B + 1);
  localparam logic [CW-1:0] B_CNT  = CW'(B);
  localparam bit            ATOMIC = (VC_REALLOC_TYPE == "ATOMIC");

  typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_EMPTY} ovc_state_e;

  typedef struct packed {
    logic ovf;
    logic udf;
    logic alloc;
    logic send;
  } err_t;

  ovc_state_e    state_q [V];
  logic [CW-1:0] cnt_q   [V];
  logic [CW-1:0] cnt_d   [V];
  logic [V-1:0]  dec, grant, idle_vec, active_vec;
  logic          send_legal, alloc_multi;
  err_t          err_q, err_ev;

  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latches).
    send_legal  = bus.flit_sent && $onehot(bus.flit_sent_vc);
    alloc_multi = !$onehot0(bus.ovc_allocated);
    dec         = send_legal ? bus.flit_sent_vc : '0;
    grant       = alloc_multi ? '0 : bus.ovc_allocated;
    err_ev      = '0;
    for (int v = 0; v < V; v++) begin
      idle_vec[v]   = (state_q[v] == IDLE);
      active_vec[v] = (state_q[v] == ACTIVE);
      cnt_d[v]      = cnt_q[v];
      if (bus.credit_in[v] && !dec[v]) begin
        if (cnt_q[v] == B_CNT) err_ev.ovf = 1'b1;
        else                   cnt_d[v]   = cnt_q[v] + CW'(1);
      end else if (dec[v] && !bus.credit_in[v]) begin
        if (cnt_q[v] == '0) err_ev.udf = 1'b1;
        else                cnt_d[v]   = cnt_q[v] - CW'(1);
      end
    end
    err_ev.alloc = alloc_multi || |(bus.ovc_allocated & ~idle_vec);
    err_ev.send  = bus.flit_sent && (!send_legal || |(bus.flit_sent_vc & ~active_vec));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all VCs update from the same old values.
    if (reset) begin
      for (int v = 0; v < V; v++) begin
        state_q[v] <= IDLE;
        cnt_q[v]   <= B_CNT;
      end
      err_q <= '0;
    end else begin
      for (int v = 0; v < V; v++) begin
        cnt_q[v] <= cnt_d[v];
        unique case (state_q[v])
          IDLE:       if (grant[v]) state_q[v] <= ACTIVE;
          // Atomic reallocation holds the VC until the downstream buffer has fully drained.
          ACTIVE:     if (dec[v] && bus.flit_sent_is_tail)
                        state_q[v] <= (!ATOMIC || cnt_d[v] == B_CNT) ? IDLE : WAIT_EMPTY;
          WAIT_EMPTY: if (cnt_d[v] == B_CNT) state_q[v] <= IDLE;
          default:    state_q[v] <= IDLE;
        endcase
      end
      if (DEBUG_EN) err_q <= err_q | err_ev;
    end
  end

  always_comb begin
    bus.credit_count = '0;
    for (int v = 0; v < V; v++) begin
      bus.ovc_avb[v]                = (state_q[v] == IDLE);
      bus.ovc_not_full[v]           = (cnt_q[v] != '0);
      bus.ovc_nearly_full[v]        = (cnt_q[v] <= CW'(1));
      bus.credit_count[v*CW +: CW] = cnt_q[v];
    end
  end

  assign bus.any_ovc_avb          = |bus.ovc_avb;
  assign bus.err_credit_overflow  = err_q.ovf;
  assign bus.err_credit_underflow = err_q.udf;
  assign bus.err_bad_alloc        = err_q.alloc;
  assign bus.err_bad_send         = err_q.send;

endmodule

// File: tb/tb_output_vc_status_tracker.sv
// Drives a NONATOMIC and an ATOMIC tracker with identical stimulus and
// compares both against an ownership/credit reference model.
module tb_output_vc_status_tracker;
  localparam int V  = 4;
  localparam int B  = 4;
  localparam int CW = $clog2(B + 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [V-1:0] alloc = '0;
  logic         fsent = 1'b0;
  logic [V-1:0] svc = '0;
  logic         tail = 1'b0;
  logic [V-1:0] cred = '0;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m=0 NONATOMIC, m=1 ATOMIC.
  int m_cred  [2][V];
  bit m_own   [2][V];
  bit m_drain [2][V];
  bit m_eo [2], m_eu [2], m_ea [2], m_es [2];

  always #5 clk = ~clk;

  output_vc_status_tracker_if #(.V(V), .CW(CW)) if_n ();
  output_vc_status_tracker_if #(.V(V), .CW(CW)) if_a ();

  assign if_n.ovc_allocated = alloc;     assign if_a.ovc_allocated = alloc;
  assign if_n.flit_sent = fsent;         assign if_a.flit_sent = fsent;
  assign if_n.flit_sent_vc = svc;        assign if_a.flit_sent_vc = svc;
  assign if_n.flit_sent_is_tail = tail;  assign if_a.flit_sent_is_tail = tail;
  assign if_n.credit_in = cred;          assign if_a.credit_in = cred;

  output_vc_status_tracker #(.V(V), .B(B), .VC_REALLOC_TYPE("NONATOMIC"), .DEBUG_EN(1'b1))
    dut_n (.clk(clk), .reset(rst), .bus(if_n));
  output_vc_status_tracker #(.V(V), .B(B), .VC_REALLOC_TYPE("ATOMIC"), .DEBUG_EN(1'b1))
    dut_a (.clk(clk), .reset(rst), .bus(if_a));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_init(input int m);
    for (int v = 0; v < V; v++) begin
      m_cred[m][v] = B; m_own[m][v] = 1'b0; m_drain[m][v] = 1'b0;
    end
    m_eo[m] = 1'b0; m_eu[m] = 1'b0; m_ea[m] = 1'b0; m_es[m] = 1'b0;
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit legal;
      legal = fsent && ($countones(svc) == 1);
      if (rst) model_init(m);
      else begin
        if (fsent && !legal) m_es[m] = 1'b1;
        if ($countones(alloc) > 1) m_ea[m] = 1'b1;
        for (int v = 0; v < V; v++) begin
          int d, t;
          bit own, dr;
          d   = (legal && svc[v]) ? 1 : 0;
          t   = m_cred[m][v] + (cred[v] ? 1 : 0) - d;
          own = m_own[m][v];
          dr  = m_drain[m][v];
          if (t > B) begin t = B; m_eo[m] = 1'b1; end
          if (t < 0) begin t = 0; m_eu[m] = 1'b1; end
          if (d == 1 && !own) m_es[m] = 1'b1;
          if (own && d == 1 && tail) begin
            m_own[m][v] = 1'b0;
            if (m == 1 && t != B) m_drain[m][v] = 1'b1;
          end else if (dr && t == B) m_drain[m][v] = 1'b0;
          if ($countones(alloc) == 1 && alloc[v]) begin
            if (own || dr) m_ea[m] = 1'b1;
            else           m_own[m][v] = 1'b1;
          end
          m_cred[m][v] = t;
        end
      end
    end
  endtask

  function automatic logic [V*CW-1:0] exp_cc(input int m);
    logic [V*CW-1:0] r;
    for (int v = 0; v < V; v++) r[v*CW +: CW] = CW'(m_cred[m][v]);
    return r;
  endfunction

  function automatic logic [V-1:0] exp_avb(input int m);
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = !m_own[m][v] && !m_drain[m][v];
    return r;
  endfunction

  function automatic logic [V-1:0] exp_nf(input int m);
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = (m_cred[m][v] > 0);
    return r;
  endfunction

  function automatic logic [V-1:0] exp_nearly(input int m);
    logic [V-1:0] r;
    for (int v = 0; v < V; v++) r[v] = (m_cred[m][v] < 2);
    return r;
  endfunction

  task automatic compare_all();
    check("nonatomic credit_count", 32'(if_n.credit_count), 32'(exp_cc(0)));
    check("nonatomic ovc_avb", 32'(if_n.ovc_avb), 32'(exp_avb(0)));
    check("nonatomic any_ovc_avb", 32'(if_n.any_ovc_avb), 32'(|exp_avb(0)));
    check("nonatomic ovc_not_full", 32'(if_n.ovc_not_full), 32'(exp_nf(0)));
    check("nonatomic ovc_nearly_full", 32'(if_n.ovc_nearly_full), 32'(exp_nearly(0)));
    check("nonatomic err flags",
          32'({if_n.err_credit_overflow, if_n.err_credit_underflow, if_n.err_bad_alloc, if_n.err_bad_send}),
          32'({m_eo[0], m_eu[0], m_ea[0], m_es[0]}));
    check("atomic credit_count", 32'(if_a.credit_count), 32'(exp_cc(1)));
    check("atomic ovc_avb", 32'(if_a.ovc_avb), 32'(exp_avb(1)));
    check("atomic any_ovc_avb", 32'(if_a.any_ovc_avb), 32'(|exp_avb(1)));
    check("atomic ovc_not_full", 32'(if_a.ovc_not_full), 32'(exp_nf(1)));
    check("atomic ovc_nearly_full", 32'(if_a.ovc_nearly_full), 32'(exp_nearly(1)));
    check("atomic err flags",
          32'({if_a.err_credit_overflow, if_a.err_credit_underflow, if_a.err_bad_alloc, if_a.err_bad_send}),
          32'({m_eo[1], m_eu[1], m_ea[1], m_es[1]}));
  endtask

  task automatic step(input logic [V-1:0] a, input logic s, input logic [V-1:0] sv,
                      input logic t, input logic [V-1:0] c);
    alloc = a; fsent = s; svc = sv; tail = t; cred = c;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step('0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rand_step(input bit legal);
    logic [V-1:0] a, sv, c;
    logic         s, t;
    int           cand [$];
    a = '0; sv = '0; c = '0; s = 1'b0; t = ($urandom_range(0, 2) == 0);
    rst = ($urandom_range(0, 99) == 0);
    if (legal) begin
      for (int v = 0; v < V; v++) if (!m_own[1][v] && !m_drain[1][v]) cand.push_back(v);
      if (cand.size() > 0 && $urandom_range(0, 3) == 0)
        a[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
      cand.delete();
      for (int v = 0; v < V; v++) if (m_own[1][v] && m_cred[1][v] > 0) cand.push_back(v);
      if (cand.size() > 0 && $urandom_range(0, 1) == 0) begin
        s = 1'b1;
        sv[cand[$urandom_range(0, cand.size() - 1)]] = 1'b1;
      end
      for (int v = 0; v < V; v++) c[v] = (m_cred[1][v] < B) && ($urandom_range(0, 2) == 0);
    end else begin
      if ($urandom_range(0, 2) == 0) a = V'(1) << $urandom_range(0, V - 1);
      s  = $urandom_range(0, 1) == 1;
      sv = V'($urandom_range(0, (1 << V) - 1));
      c  = V'($urandom_range(0, (1 << V) - 1));
    end
    step(a, s, sv, t, c);
    rst = 1'b0;
  endtask

  initial begin
    model_init(0);
    model_init(1);
    rst = 1'b1;
    idle();
    idle();
    check("reset ovc_avb", 32'(if_n.ovc_avb), 32'h0000_000f);
    check("reset credit_count", 32'(if_a.credit_count), 32'h0000_0924);
    check("reset nearly_full", 32'(if_n.ovc_nearly_full), 32'h0);
    rst = 1'b0;

    // Grant VC1 and drain its credits with body flits.
    step(4'b0010, 1'b0, '0, 1'b0, '0);
    check("grant vc1 ovc_avb", 32'(if_n.ovc_avb), 32'h0000_000d);
    for (int k = 3; k >= 0; k--) begin
      step('0, 1'b1, 4'b0010, 1'b0, '0);
      check("vc1 count", 32'(if_n.credit_count[1*CW +: CW]), 32'(k));
    end
    check("vc1 not_full at 0", 32'(if_n.ovc_not_full[1]), 32'h0);

    // Credit and send together at zero: no change, no underflow.
    step('0, 1'b1, 4'b0010, 1'b0, 4'b0010);
    check("vc1 inc+dec at 0", 32'(if_n.credit_count[1*CW +: CW]), 32'h0);
    check("no underflow", 32'(if_n.err_credit_underflow), 32'h0);
    step('0, 1'b0, '0, 1'b0, 4'b0010);
    check("vc1 credit back", 32'(if_n.credit_count[1*CW +: CW]), 32'h1);
    check("vc1 nearly_full at 1", 32'(if_n.ovc_nearly_full[1]), 32'h1);
    repeat (3) step('0, 1'b0, '0, 1'b0, 4'b0010);

    // VC2: body then tail leaves count 2; atomic waits for both credits.
    step(4'b0100, 1'b0, '0, 1'b0, '0);
    step('0, 1'b1, 4'b0100, 1'b0, '0);
    step('0, 1'b1, 4'b0100, 1'b1, '0);
    check("nonatomic vc2 freed", 32'(if_n.ovc_avb[2]), 32'h1);
    check("atomic vc2 waiting", 32'(if_a.ovc_avb[2]), 32'h0);
    step('0, 1'b0, '0, 1'b0, 4'b0100);
    check("atomic vc2 after 1st credit", 32'(if_a.ovc_avb[2]), 32'h0);
    step('0, 1'b0, '0, 1'b0, 4'b0100);
    check("atomic vc2 after 2nd credit", 32'(if_a.ovc_avb[2]), 32'h1);

    // Protocol errors.
    step('0, 1'b0, '0, 1'b0, 4'b0001);
    check("overflow flag", 32'(if_n.err_credit_overflow), 32'h1);
    check("overflow count held", 32'(if_n.credit_count[0 +: CW]), 32'h4);
    step(4'b0010, 1'b0, '0, 1'b0, '0);
    check("bad alloc flag", 32'(if_a.err_bad_alloc), 32'h1);
    step('0, 1'b1, 4'b0011, 1'b0, '0);
    check("bad send flag", 32'(if_n.err_bad_send), 32'h1);
    check("bad send no count change", 32'(if_n.credit_count), 32'h0000_0924);

    // Reset mid-packet on VC3.
    step(4'b1000, 1'b0, '0, 1'b0, '0);
    repeat (3) step('0, 1'b1, 4'b1000, 1'b0, '0);
    check("vc3 count before reset", 32'(if_a.credit_count[3*CW +: CW]), 32'h1);
    rst = 1'b1;
    step(4'b0001, 1'b1, 4'b1000, 1'b1, 4'b0100);
    rst = 1'b0;
    check("reset vc3 avb", 32'(if_a.ovc_avb), 32'h0000_000f);
    check("reset vc3 count", 32'(if_a.credit_count), 32'h0000_0924);
    check("reset clears errors",
          32'({if_n.err_credit_overflow, if_n.err_bad_alloc, if_n.err_bad_send}), 32'h0);

    repeat (2000) rand_step(1'b1);
    repeat (1500) rand_step(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end
endmodule
